// File: rtl/final2_soc_nios2_qsys_0_mul_unit.sv
// ---------------------------------------------------------------------------
// final2_soc_nios2_qsys_0_mul_unit
//
// Iterative integer multiplier for the CPU core. A request is reduced to
// unsigned operand magnitudes plus a result sign. The unsigned product is then
// built one PART_W x PART_W partial product per clock in a 2*WIDTH
// accumulator, and the product is negated back once at the end. The low half
// of the product is returned for MUL. The high half is returned for MULH,
// MULHSU and MULHU.
//
// Ports
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   in_valid    request valid
//   in_ready    unit is idle and accepts a request
//   in_mode     00 MUL, 01 MULH (s x s), 10 MULHSU (s x u), 11 MULHU (u x u)
//   in_src1/2   operands, WIDTH bits each
//   abort       synchronous cancel of the operation in flight
//   out_valid   result available (held until out_ready)
//   out_ready   consumer takes the result
//   out_result  selected half of the product
// ---------------------------------------------------------------------------
module final2_soc_nios2_qsys_0_mul_unit #(
    parameter int WIDTH  = 32,
    parameter int PART_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [WIDTH-1:0] in_src1,
    input  logic [WIDTH-1:0] in_src2,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result
);

    localparam int D  = WIDTH / PART_W;
    localparam int K  = D * D;
    localparam int DW = (D > 1) ? $clog2(D) : 1;
    // The digit-index sum j+k reaches 2*D-2 and needs one more bit than an index.
    localparam int SW = DW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Two's-complement magnitude of an operand that is known to be negative.
    // The most negative value maps onto itself, which is the correct unsigned
    // magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    state_t               state_q, state_d;
    logic [1:0]           mode_q, mode_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 sign_q, sign_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    // The digit counter c = j*D + k is kept as its two digit indices.
    logic [DW-1:0]        j_q, j_d;
    logic [DW-1:0]        k_q, k_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_result_q, out_result_d;

    logic                 src1_signed_s, src2_signed_s;
    logic                 neg1_s, neg2_s;
    logic [PART_W-1:0]    a_dig_s, b_dig_s;
    logic [2*PART_W-1:0]  pp_s;
    logic [2*WIDTH-1:0]   pp_ext_s;
    logic [SW-1:0]        sum_s;
    logic [2*WIDTH-1:0]   addend_s;
    logic [2*WIDTH-1:0]   res_full_s;

    // Operand signedness and sign of the incoming request.
    always_comb begin
        src1_signed_s = (in_mode == 2'b01) || (in_mode == 2'b10);
        src2_signed_s = (in_mode == 2'b01);
        neg1_s        = src1_signed_s & in_src1[WIDTH-1];
        neg2_s        = src2_signed_s & in_src2[WIDTH-1];
    end

    // Select the current digits and position their partial product in the accumulator.
    always_comb begin
        a_dig_s = {PART_W{1'b0}};
        b_dig_s = {PART_W{1'b0}};
        // A one-hot OR-mux over constant slices keeps every select index static.
        for (int i = 0; i < D; i++) begin
            a_dig_s = a_dig_s | ((j_q == DW'(i)) ? a_q[i*PART_W +: PART_W] : {PART_W{1'b0}});
            b_dig_s = b_dig_s | ((k_q == DW'(i)) ? b_q[i*PART_W +: PART_W] : {PART_W{1'b0}});
        end
        pp_s     = {{PART_W{1'b0}}, a_dig_s} * {{PART_W{1'b0}}, b_dig_s};
        pp_ext_s = '0;
        pp_ext_s[2*PART_W-1:0] = pp_s;
        sum_s    = {1'b0, j_q} + {1'b0, k_q};
        addend_s = '0;
        for (int s = 0; s <= 2*D-2; s++) begin
            addend_s = addend_s | ((sum_s == SW'(s)) ? (pp_ext_s << (s*PART_W)) : '0);
        end
        res_full_s = sign_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
    end

    // Next-state and next-register logic of the IDLE -> MUL -> FIX -> DONE sequence.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        a_d          = a_q;
        b_d          = b_q;
        sign_d       = sign_q;
        acc_d        = acc_q;
        j_d          = j_q;
        k_d          = k_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;

        if (abort) begin
            // A cancel wins over everything, including a new request in IDLE.
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        mode_d  = in_mode;
                        a_d     = magnitude(in_src1, neg1_s);
                        b_d     = magnitude(in_src2, neg2_s);
                        sign_d  = neg1_s ^ neg2_s;
                        acc_d   = '0;
                        j_d     = '0;
                        k_d     = '0;
                        state_d = ST_MUL;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_MUL: begin
                    acc_d = acc_q + addend_s;
                    if (k_q == DW'(D-1)) begin
                        k_d = '0;
                        if (j_q == DW'(D-1)) begin
                            j_d     = '0;
                            state_d = ST_FIX;
                        end else begin
                            j_d = j_q + DW'(1);
                        end
                    end else begin
                        k_d = k_q + DW'(1);
                    end
                end
                ST_FIX: begin
                    out_result_d = (mode_q == 2'b00) ? res_full_s[WIDTH-1:0]
                                                     : res_full_s[2*WIDTH-1:WIDTH];
                    out_valid_d  = 1'b1;
                    state_d      = ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            mode_q       <= 2'b00;
            a_q          <= '0;
            b_q          <= '0;
            sign_q       <= 1'b0;
            acc_q        <= '0;
            j_q          <= '0;
            k_q          <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sign_q       <= sign_d;
            acc_q        <= acc_d;
            j_q          <= j_d;
            k_q          <= k_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
        end
    end

    assign in_ready   = reset_n & (state_q == ST_IDLE);
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;

endmodule

// File: tb/tb_final2_soc_nios2_qsys_0_mul_unit.sv
module tb_final2_soc_nios2_qsys_0_mul_unit;

    localparam int K32 = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid32 = 1'b0;
    logic        in_valid64 = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [63:0] src1 = 64'h0;
    logic [63:0] src2 = 64'h0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready32, out_valid32;
    logic [31:0] out_result32;
    logic        in_ready64, out_valid64;
    logic [63:0] out_result64;

    int n_checks = 0;
    int n_fail   = 0;

    final2_soc_nios2_qsys_0_mul_unit #(.WIDTH(32), .PART_W(16)) dut32 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .in_mode(mode), .in_src1(src1[31:0]), .in_src2(src2[31:0]), .abort(abort),
        .out_valid(out_valid32), .out_ready(out_ready), .out_result(out_result32)
    );

    final2_soc_nios2_qsys_0_mul_unit #(.WIDTH(64), .PART_W(16)) dut64 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid64), .in_ready(in_ready64),
        .in_mode(mode), .in_src1(src1), .in_src2(src2), .abort(abort),
        .out_valid(out_valid64), .out_ready(out_ready), .out_result(out_result64)
    );

    always #5 clk = ~clk;

    // Reference: full-width product of the (sign- or zero-)extended operands.
    function automatic logic [31:0] ref32(input logic [1:0] md, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (md == 2'b01 || md == 2'b10) ? {{32{a[31]}}, a} : {32'h0, a};
        eb = (md == 2'b01) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        return (md == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Transaction-level model of the 32-bit unit.
    logic        m_busy, m_valid;
    int          m_cnt;
    logic [31:0] m_res, m_pend;
    wire         m_ready = !m_busy && !m_valid;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_cnt   <= 0;
        end else if (abort) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
        end else if (m_valid) begin
            if (out_ready) m_valid <= 1'b0;
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                m_busy  <= 1'b0;
                m_valid <= 1'b1;
                m_res   <= m_pend;
            end
            m_cnt <= m_cnt - 1;
        end else if (in_valid32) begin
            m_busy <= 1'b1;
            m_cnt  <= K32 + 1;
            m_pend <= ref32(mode, src1[31:0], src2[31:0]);
        end
    end

    // Cycle-by-cycle comparison of the 32-bit unit against the model.
    always @(negedge clk) begin
        if (reset_n) begin
            n_checks = n_checks + 1;
            if (in_ready32 !== m_ready) begin
                n_fail = n_fail + 1;
                $display("FAIL cmp_in_ready t=%0t: got %b expected %b", $time, in_ready32, m_ready);
            end
            n_checks = n_checks + 1;
            if (out_valid32 !== m_valid) begin
                n_fail = n_fail + 1;
                $display("FAIL cmp_out_valid t=%0t: got %b expected %b", $time, out_valid32, m_valid);
            end
            if (m_valid) begin
                n_checks = n_checks + 1;
                if (out_result32 !== m_res) begin
                    n_fail = n_fail + 1;
                    $display("FAIL cmp_out_result t=%0t: got 0x%h expected 0x%h", $time, out_result32, m_res);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    // Issue one request, scramble the inputs after acceptance, wait for out_valid.
    task automatic do_op(input bit w64, input logic [1:0] md, input logic [63:0] a,
                         input logic [63:0] b, output logic [63:0] res, output int lat);
        @(posedge clk); #1;
        mode = md; src1 = a; src2 = b;
        if (w64) in_valid64 = 1'b1; else in_valid32 = 1'b1;
        @(posedge clk); #1;
        in_valid32 = 1'b0; in_valid64 = 1'b0;
        mode = 2'($urandom); src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom};
        lat = 0;
        while (((w64 ? out_valid64 : out_valid32) !== 1'b1) && lat < 100) begin
            @(posedge clk); #1;
            lat = lat + 1;
        end
        res = w64 ? out_result64 : {32'h0, out_result32};
    endtask

    task automatic take_result(input string nm);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, "_valid_low"}, {63'h0, out_valid32}, 64'h0);
        chk({nm, "_ready_high"}, {63'h0, in_ready32}, 64'h1);
    endtask

    typedef struct {
        logic [1:0]  md;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    initial begin
        vec_t        vecs[$];
        logic [63:0] res;
        int          lat;
        int          rises;

        vecs.push_back('{2'b00, 32'h00010003, 32'h00020005, 32'h000B000F, "mul_basic"});
        vecs.push_back('{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "mulh_m1"});
        vecs.push_back('{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_m1"});
        vecs.push_back('{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, "mul_m1"});
        vecs.push_back('{2'b10, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, "mulhsu_min"});
        vecs.push_back('{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, "mulh_min"});
        vecs.push_back('{2'b01, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, "mulh_neg"});
        vecs.push_back('{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, "mul_neg"});
        vecs.push_back('{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_m1"});

        // Reset state, checked while reset is held and just after release.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", {63'h0, out_valid32}, 64'h0);
        chk("reset_out_result", {32'h0, out_result32}, 64'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", {63'h0, in_ready32}, 64'h1);
        chk("idle_out_valid", {63'h0, out_valid32}, 64'h0);

        // Directed vectors with literal results and latency.
        foreach (vecs[i]) begin
            do_op(1'b0, vecs[i].md, {32'h0, vecs[i].a}, {32'h0, vecs[i].b}, res, lat);
            chk(vecs[i].nm, res, {32'h0, vecs[i].exp});
            chk({vecs[i].nm, "_lat"}, 64'(lat), 64'd5);
            take_result(vecs[i].nm);
        end

        // Backpressure: result and handshake must hold while out_ready is low.
        do_op(1'b0, 2'b00, 64'd7, 64'd9, res, lat);
        chk("bp_result", res, 64'h3F);
        repeat (10) begin
            @(posedge clk); #1;
            chk("bp_hold_result", {32'h0, out_result32}, 64'h3F);
            chk("bp_hold_in_ready", {63'h0, in_ready32}, 64'h0);
            chk("bp_hold_valid", {63'h0, out_valid32}, 64'h1);
        end
        take_result("bp");

        // Abort in the second MUL cycle: no result, idle again right away.
        @(posedge clk); #1;
        mode = 2'b00; src1 = 64'd3; src2 = 64'd5; in_valid32 = 1'b1;
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_in_ready", {63'h0, in_ready32}, 64'h1);
        rises = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid32) rises = rises + 1;
        end
        chk("abort_no_valid", 64'(rises), 64'h0);
        do_op(1'b0, 2'b11, 64'd3, 64'd5, res, lat);
        chk("post_abort_mulhu", res, 64'h0);
        take_result("post_abort_mulhu");
        do_op(1'b0, 2'b00, 64'd3, 64'd5, res, lat);
        chk("post_abort_mul", res, 64'hF);
        take_result("post_abort_mul");

        // abort together with in_valid in IDLE: request must be dropped.
        @(posedge clk); #1;
        mode = 2'b00; src1 = 64'd6; src2 = 64'd7; in_valid32 = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        in_valid32 = 1'b0; abort = 1'b0;
        chk("abort_wins_ready", {63'h0, in_ready32}, 64'h1);
        rises = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid32) rises = rises + 1;
        end
        chk("abort_wins_no_valid", 64'(rises), 64'h0);

        // Reset pulse while the unit is in FIX.
        @(posedge clk); #1;
        mode = 2'b00; src1 = 64'd11; src2 = 64'd13; in_valid32 = 1'b1;
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        repeat (K32) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_fix_valid", {63'h0, out_valid32}, 64'h0);
        chk("rst_fix_result", {32'h0, out_result32}, 64'h0);
        #2;
        reset_n = 1'b1;
        rises = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid32) rises = rises + 1;
        end
        chk("rst_fix_no_late", 64'(rises), 64'h0);
        chk("rst_fix_ready", {63'h0, in_ready32}, 64'h1);

        // 64-bit instance: MULHU of all-ones operands, latency K+1 = 17.
        do_op(1'b1, 2'b11, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, res, lat);
        chk("w64_mulhu", res, 64'hFFFFFFFFFFFFFFFE);
        chk("w64_lat", 64'(lat), 64'd17);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("w64_valid_low", {63'h0, out_valid64}, 64'h0);
        chk("w64_ready_high", {63'h0, in_ready64}, 64'h1);

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
